pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Owns the architectural program counter (PC) and sequences instruction fetch over a request/grant/response handshake to instruction memory.
- Selects the next PC from three sources: sequential PC+4, branch/jump redirect, or hold on stall.
- Presents fetched instructions to decode through a valid/ready handshake.
- Sits between the PC incrementer, the instruction memory port and the IF/ID boundary.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  hazard stall; blocks handoff of the held instruction to decode.
- redirect_valid_i  in  1  branch/jump taken this cycle.
- redirect_target_i  in  32  new PC when redirect_valid_i=1.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals the PC register.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; arrives ≥1 cycle after the grant; at most 1 outstanding.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  instruction available to decode.
- if_ready_i  in  1  decode accepts.
- if_pc_o  out  32  PC of the presented instruction.
- if_instr_o  out  32  presented instruction.
- misalign_o  out  1  1-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (rst=1 at an edge, from any state):
  - state=S_RESET, pc=RESET_VECTOR.
  - imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, misalign_o=0.
  - Any outstanding memory response is forgotten.
- State S_RESET: after one cycle -> S_REQ.
- State S_REQ:
  - imem_req_o=1, imem_addr_o=pc.
  - imem_gnt_i=1 -> S_WAIT. Otherwise stay in S_REQ; the address stays stable.
- State S_WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i, the next edge captures: if_instr_o<=imem_rdata_i, if_pc_o<=pc, if_valid_o<=1, pc<=pc+4; state -> S_HOLD.
- State S_HOLD:
  - if_valid_o=1; if_pc_o and if_instr_o are stable.
  - if_ready_i=1 and stall_i=0 -> if_valid_o<=0, -> S_REQ (fetch of the new pc issues the following cycle).
  - Otherwise hold.
- Fetch latency: request to if_valid_o is a minimum of 2 cycles (grant in the request cycle, rvalid the next cycle).
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. pc[1:0] is always 00.
- Redirect with a word-aligned target (redirect_target_i[1:0]=00):
  - Always sets pc<=target and if_valid_o<=0; this takes priority over if_ready_i and rvalid capture.
  - From S_RESET or S_HOLD: -> S_REQ. The held instruction is discarded even if if_ready_i=1 in the same cycle.
  - From S_REQ, gnt=0: stays in S_REQ; imem_addr_o shows the new pc next cycle. The memory port tolerates the address change before grant.
  - From S_REQ, gnt=1: the stale request is in flight -> S_DROP.
  - From S_WAIT, rvalid=0: -> S_DROP.
  - From S_WAIT, rvalid=1: the response is discarded (no capture) -> S_REQ.
  - From S_DROP, rvalid=0: pc updated, stay in S_DROP.
  - From S_DROP, rvalid=1: pc updated -> S_REQ.
- State S_DROP:
  - imem_req_o=0, if_valid_o=0.
  - Waits for the stale imem_rvalid_i, discards the data -> S_REQ.
- Redirect with a misaligned target (redirect_target_i[1:0]≠00):
  - Redirect is ignored; pc and state behave as if redirect_valid_i=0.
  - misalign_o=1 for exactly the next cycle.
- stall_i: affects only the S_HOLD handoff. It does not block outstanding responses or redirects.
- Reset mid-transaction (e.g. in S_WAIT): the pending rvalid arriving after reset is ignored because state is S_RESET/S_REQ, not S_WAIT.

Test Plan:
- Reset, RESET_VECTOR=0x100, gnt and rvalid always in the next cycle, ready=1 -> fetch addresses 0x100, 0x104, 0x108; if_pc_o matches each; if_instr_o equals the memory data.
- Hold gnt=0 for 3 cycles in S_REQ -> imem_req_o=1 and addr 0x100 stable all 3 cycles; exactly one fetch after gnt.
- Instruction in S_HOLD with stall_i=1 for 4 cycles, then 0 -> if_valid_o, if_pc_o and if_instr_o stable for 4 cycles; next request is addr+4.
- Redirect to 0x200 while in S_WAIT -> stale rvalid data is not presented (if_valid_o stays 0); next request addr=0x200, then if_pc_o=0x200.
- Redirect to 0x202 -> misalign_o high for 1 cycle; PC sequence continues unchanged.
- pc=0xFFFF_FFFC fetched and handed off -> next request addr=0x0000_0000; assert rst during S_WAIT -> pc=RESET_VECTOR, if_valid_o=0, and a late rvalid is ignored.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding imem request
// at a time and hands fetched words to decode over a valid/ready boundary.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        misalign_o
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        misalign_q, misalign_d;
  logic        redir_ok;

  // Misaligned targets are dropped entirely; only the pulse records them.
  assign redir_ok = redirect_valid_i && (redirect_target_i[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    misalign_d = redirect_valid_i && (redirect_target_i[1:0] != 2'b00);

    if (redir_ok) begin
      pc_d       = redirect_target_i;
      if_valid_d = 1'b0;
    end

    case (state_q)
      S_RESET: state_d = S_REQ;
      S_REQ: begin
        // A granted request still returns data for the old pc; drain it.
        if (imem_gnt_i) state_d = redir_ok ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redir_ok) begin
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          if_instr_d = imem_rdata_i;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir_ok) begin
          state_d = S_REQ;
        end else if (if_ready_i && !stall_i) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      pc_q       <= RESET_VECTOR;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a memory model grants queued addresses,
// and a handoff monitor pops expected PCs when decode accepts an instruction.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_valid_o, if_ready_i, misalign_o;
  logic [31:0] if_pc_o, if_instr_o;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] hand_q[$];
  int          rsp_lat = 1;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_addr_q.size() != 0 || hand_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(exp_addr_q.size() + hand_q.size()), 32'd0);
    tick();
  endtask

  // Memory model: grants only addresses the test expects, one outstanding.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] paddr, a;
    pend = 1'b0; cnt = 0; paddr = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      imem_rvalid_i = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(paddr);
          pend = 1'b0;
        end
      end
      imem_gnt_i = 1'b0;
      if (imem_req_o && exp_addr_q.size() != 0) begin
        a = exp_addr_q.pop_front();
        chk("fetch_addr", imem_addr_o, a);
        imem_gnt_i = 1'b1;
        pend  = 1'b1;
        cnt   = rsp_lat;
        paddr = imem_addr_o;
      end
    end
  end

  // Handoff monitor: decode takes the instruction at the coming edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && if_valid_o && if_ready_i && !stall_i &&
          !(redirect_valid_i && redirect_target_i[1:0] == 2'b00)) begin
        chk("handoff_expected", 32'(hand_q.size() != 0), 32'd1);
        if (hand_q.size() != 0) begin
          e = hand_q.pop_front();
          chk("if_pc", if_pc_o, e);
          chk("if_instr", if_instr_o, mem_word(e));
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_target_i = '0; if_ready_i = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h100);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_instr", if_instr_o, 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);

    // Back-to-back sequential fetches
    rst = 1'b0; if_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(32'h100 + 32'(4 * i));
      hand_q.push_back(32'h100 + 32'(4 * i));
    end
    wait_idle(40);

    // Grant withheld: request and address must hold
    for (int i = 0; i < 3; i++) begin
      chk("nogrant_req", 32'(imem_req_o), 32'd1);
      chk("nogrant_addr", imem_addr_o, 32'h10C);
      tick();
    end
    exp_addr_q.push_back(32'h10C); hand_q.push_back(32'h10C);
    wait_idle(20);
    chk("one_fetch_addr", imem_addr_o, 32'h110);

    // Stall holds the presented instruction
    stall_i = 1'b1;
    exp_addr_q.push_back(32'h110); hand_q.push_back(32'h110);
    n = 0;
    while (!if_valid_o && n < 20) begin tick(); n++; end
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", 32'(if_valid_o), 32'd1);
      chk("stall_pc", if_pc_o, 32'h110);
      chk("stall_instr", if_instr_o, mem_word(32'h110));
      tick();
    end
    stall_i = 1'b0;
    exp_addr_q.push_back(32'h114); hand_q.push_back(32'h114);
    wait_idle(20);

    // Redirect while waiting: stale response must be dropped
    rsp_lat = 3;
    exp_addr_q.push_back(32'h118);
    n = 0;
    while (exp_addr_q.size() != 0 && n < 20) begin tick(); n++; end
    tick();
    redirect_valid_i = 1'b1; redirect_target_i = 32'h200;
    tick();
    redirect_valid_i = 1'b0;
    chk("drop_valid", 32'(if_valid_o), 32'd0);
    chk("drop_req", 32'(imem_req_o), 32'd0);
    rsp_lat = 1;
    exp_addr_q.push_back(32'h200); hand_q.push_back(32'h200);
    tick();
    chk("drop_valid2", 32'(if_valid_o), 32'd0);
    wait_idle(20);

    // Misaligned redirect is ignored but pulses misalign_o once
    redirect_valid_i = 1'b1; redirect_target_i = 32'h202;
    tick();
    redirect_valid_i = 1'b0;
    chk("misalign_pulse", 32'(misalign_o), 32'd1);
    chk("misalign_addr", imem_addr_o, 32'h204);
    tick();
    chk("misalign_clear", 32'(misalign_o), 32'd0);
    exp_addr_q.push_back(32'h204); hand_q.push_back(32'h204);
    wait_idle(20);

    // PC wrap at the top of the address space
    redirect_valid_i = 1'b1; redirect_target_i = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    chk("wrap_redirect_addr", imem_addr_o, 32'hFFFF_FFFC);
    exp_addr_q.push_back(32'hFFFF_FFFC); hand_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);         hand_q.push_back(32'h0);
    wait_idle(30);

    // Reset mid-transaction; late rvalid must not be captured
    rsp_lat = 3;
    exp_addr_q.push_back(32'h4);
    n = 0;
    while (exp_addr_q.size() != 0 && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(if_valid_o), 32'd0);
    chk("midrst_addr", imem_addr_o, 32'h100);
    chk("midrst_req", 32'(imem_req_o), 32'd0);
    tick(); tick();
    chk("late_rvalid_valid", 32'(if_valid_o), 32'd0);
    chk("late_rvalid_req", 32'(imem_req_o), 32'd1);
    chk("late_rvalid_addr", imem_addr_o, 32'h100);
    rsp_lat = 1;
    exp_addr_q.push_back(32'h100); hand_q.push_back(32'h100);
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
